// File: rtl/udp_panel_writer.sv
// udp_panel_writer: turns LiteEth UDP pixel packets into ledpanel write strobes
module udp_panel_writer #(
  parameter int          NUM_PANELS = 6,
  parameter logic [15:0] UDP_PORT   = 16'd6000,
  parameter logic [7:0]  MAGIC      = 8'hA5,
  parameter int          MAX_PIXELS = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  udp_source_valid,
  input  logic                  udp_source_last,
  output logic                  udp_source_ready,
  input  logic [15:0]           udp_source_dst_port,
  input  logic [31:0]           udp_source_data,
  input  logic [3:0]            udp_source_error,
  output logic [NUM_PANELS-1:0] ctrl_en,
  output logic [3:0]            ctrl_wr,
  output logic [15:0]           ctrl_addr,
  output logic [23:0]           ctrl_wdat,
  output logic                  frame_done,
  output logic [15:0]           pkt_count,
  output logic [15:0]           drop_count
);
  localparam int CW = $clog2(MAX_PIXELS + 1);
  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;
  state_t        state;
  logic [3:0]    panel, mask;
  logic [15:0]   addr;
  logic [CW-1:0] pix;
  logic          accept, err, hdr_ok;
  logic [15:0]   drop_next;
  assign accept    = udp_source_valid & udp_source_ready;
  assign err       = |udp_source_error;
  assign hdr_ok    = udp_source_data[31:24] == MAGIC && udp_source_dst_port == UDP_PORT &&
                     int'(udp_source_data[23:20]) < NUM_PANELS && !err;
  assign drop_next = &drop_count ? drop_count : drop_count + 16'd1;
  // Header parsing, one-cycle pixel write strobes and packet bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      udp_source_ready <= 1'b0;
      ctrl_en          <= '0;
      ctrl_wr          <= '0;
      ctrl_addr        <= '0;
      ctrl_wdat        <= '0;
      frame_done       <= 1'b0;
      pkt_count        <= '0;
      drop_count       <= '0;
      panel            <= '0;
      mask             <= '0;
      addr             <= '0;
      pix              <= '0;
    end else begin
      udp_source_ready <= 1'b1;
      ctrl_en          <= '0;
      frame_done       <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: if (hdr_ok) begin
            panel <= udp_source_data[23:20];
            mask  <= udp_source_data[19:16];
            addr  <= udp_source_data[15:0];
            pix   <= '0;
            if (udp_source_last) begin
              frame_done <= 1'b1;
              pkt_count  <= pkt_count + 16'd1;
            end else state <= DATA;
          end else begin
            drop_count <= drop_next;
            state      <= udp_source_last ? IDLE : DROP;
          end
          DATA: if (err) begin
            drop_count <= drop_next;
            state      <= udp_source_last ? IDLE : DROP;
          end else begin
            if (int'(pix) < MAX_PIXELS) begin
              ctrl_en   <= NUM_PANELS'(1) << panel;
              ctrl_wr   <= mask;
              ctrl_addr <= addr;
              ctrl_wdat <= udp_source_data[23:0];
              addr      <= addr + 16'd1;
              pix       <= pix + CW'(1);
            end
            if (udp_source_last) begin
              frame_done <= 1'b1;
              pkt_count  <= pkt_count + 16'd1;
              state      <= IDLE;
            end
          end
          default: if (udp_source_last) state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_udp_panel_writer.sv
// tb_udp_panel_writer: randomized packet stimulus checked against a packet-level model
module tb_udp_panel_writer;
  logic        clock = 1'b0;
  logic        reset;
  logic        udp_source_valid, udp_source_last, udp_source_ready;
  logic [15:0] udp_source_dst_port;
  logic [31:0] udp_source_data;
  logic [3:0]  udp_source_error;
  logic [5:0]  ctrl_en;
  logic [3:0]  ctrl_wr;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic        frame_done;
  logic [15:0] pkt_count, drop_count;

  udp_panel_writer #(.MAX_PIXELS(4)) dut (
    .clock(clock), .reset(reset),
    .udp_source_valid(udp_source_valid), .udp_source_last(udp_source_last),
    .udp_source_ready(udp_source_ready), .udp_source_dst_port(udp_source_dst_port),
    .udp_source_data(udp_source_data), .udp_source_error(udp_source_error),
    .ctrl_en(ctrl_en), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
    .frame_done(frame_done), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [5:0] en; logic [3:0] wr; logic [15:0] a; logic [23:0] d; } wr_t;
  wr_t         exp_q[$];
  wr_t         w;
  logic [31:0] bd[$];
  logic [3:0]  be[$];
  int          n_vec = 0, n_err = 0;
  int          m_frames = 0, act_frames = 0;
  logic [15:0] m_pkt = 0, m_drop = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Packet-level reference: which writes a whole packet should produce and how it is counted
  task automatic model_pkt(input logic [15:0] p, input bit complete);
    logic [31:0] h;
    wr_t         x;
    int          np;
    h  = bd[0];
    np = 0;
    if (h[31:24] != 8'hA5 || p != 16'd6000 || h[23:20] >= 4'd6 || be[0] != 4'd0) begin
      m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1;
      return;
    end
    for (int i = 1; i < bd.size(); i++) begin
      if (be[i] != 4'd0) begin
        m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1;
        return;
      end
      if (np < 4) begin
        x.en = 6'(1) << h[23:20];
        x.wr = h[19:16];
        x.a  = h[15:0] + 16'(np);
        x.d  = bd[i][23:0];
        exp_q.push_back(x);
      end
      np++;
    end
    if (complete) begin
      m_frames++;
      m_pkt = m_pkt + 16'd1;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, input logic [3:0] e, input logic [15:0] p);
    int n = 0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clock);
      #1;
    end
    udp_source_valid    = 1'b1;
    udp_source_data     = d;
    udp_source_last     = l;
    udp_source_error    = e;
    udp_source_dst_port = p;
    while (!udp_source_ready && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!udp_source_ready) check("ready_timeout", {63'd0, udp_source_ready}, 64'd1);
    @(posedge clock);
    #1;
    udp_source_valid = 1'b0;
    udp_source_last  = 1'b0;
  endtask

  task automatic mk(input logic [31:0] hdr, input int n, input int err_at);
    bd.delete();
    be.delete();
    bd.push_back(hdr);
    be.push_back(4'd0);
    for (int i = 0; i < n; i++) begin
      bd.push_back($urandom);
      be.push_back(i == err_at ? 4'd1 : 4'd0);
    end
  endtask

  task automatic run_pkt(input logic [15:0] p, input bit complete);
    model_pkt(p, complete);
    for (int i = 0; i < bd.size(); i++)
      send_beat(bd[i], complete && i == bd.size() - 1, be[i], p);
  endtask

  task automatic end_pkt(input string tag);
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_pkt"}, pkt_count, m_pkt);
    check({tag, "_drop"}, drop_count, m_drop);
    check({tag, "_frames"}, act_frames, m_frames);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // Every strobe must match the next write the model predicts; frame_done must coincide with the last one
  always @(negedge clock) begin
    if (ctrl_en != 6'd0) begin
      if (exp_q.size() == 0) check("spurious_wr", ctrl_en, 0);
      else begin
        w = exp_q.pop_front();
        check("wr_en", ctrl_en, w.en);
        check("wr_mask", ctrl_wr, w.wr);
        check("wr_addr", ctrl_addr, w.a);
        check("wr_wdat", ctrl_wdat, w.d);
      end
    end
    if (frame_done) begin
      act_frames++;
      check("fd_with_last_wr", exp_q.size(), 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hdr;
    logic [15:0] port;
    reset = 1'b1;
    udp_source_valid = 1'b0;
    udp_source_last = 1'b0;
    udp_source_data = '0;
    udp_source_error = '0;
    udp_source_dst_port = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_outputs", {udp_source_ready, ctrl_en, ctrl_wr, frame_done}, 0);
    check("rst_data", {ctrl_addr, ctrl_wdat}, 0);
    check("rst_counts", {pkt_count, drop_count}, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("ready_after_rst", {63'd0, udp_source_ready}, 64'd1);

    mk(32'hA507_0010, 3, -1);
    bd[1] = 32'h0011_2233;
    bd[2] = 32'h0044_5566;
    bd[3] = 32'h0077_8899;
    run_pkt(16'd6000, 1);
    end_pkt("basic");
    check("hold_addr", ctrl_addr, 16'h0012);
    check("hold_wdat", ctrl_wdat, 24'h778899);

    mk(32'hA507_0010, 3, -1);
    run_pkt(16'd5000, 1);
    end_pkt("bad_port");
    mk(32'h5A07_0010, 3, -1);
    run_pkt(16'd6000, 1);
    end_pkt("bad_magic");
    mk(32'hA567_0010, 3, -1);
    run_pkt(16'd6000, 1);
    end_pkt("bad_panel");
    mk(32'hA55C_0040, 2, -1);
    run_pkt(16'd6000, 1);
    end_pkt("after_drops");

    mk(32'hA531_0000, 0, -1);
    run_pkt(16'd6000, 1);
    end_pkt("empty");

    mk(32'hA52F_FFFE, 4, -1);
    run_pkt(16'd6000, 1);
    end_pkt("wrap");
    check("wrap_last_addr", ctrl_addr, 16'h0001);

    mk(32'hA513_0100, 6, -1);
    run_pkt(16'd6000, 1);
    end_pkt("max_pix");
    check("max_pix_last_addr", ctrl_addr, 16'h0103);

    mk(32'hA50F_0020, 3, 1);
    run_pkt(16'd6000, 1);
    end_pkt("err_beat");
    mk(32'hA50F_0030, 2, -1);
    run_pkt(16'd6000, 1);
    end_pkt("after_err");

    mk(32'hA545_0200, 2, -1);
    run_pkt(16'd6000, 0);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    check("midrst_outputs", {udp_source_ready, ctrl_en, ctrl_wr, frame_done}, 0);
    check("midrst_data", {ctrl_addr, ctrl_wdat}, 0);
    check("midrst_counts", {pkt_count, drop_count}, 0);
    check("midrst_pending", exp_q.size(), 0);
    m_pkt = 0;
    m_drop = 0;
    m_frames = 0;
    act_frames = 0;
    reset = 1'b0;
    bd.delete();
    be.delete();
    bd.push_back(32'h00AA_BBCC);
    bd.push_back(32'h00DD_EEFF);
    be.push_back(4'd0);
    be.push_back(4'd0);
    run_pkt(16'd6000, 1);
    end_pkt("tail");
    mk(32'hA527_0300, 3, -1);
    run_pkt(16'd6000, 1);
    end_pkt("recover");

    for (int k = 0; k < 60; k++) begin
      hdr = {($urandom_range(0, 7) == 0) ? 8'h5A : 8'hA5, 4'($urandom_range(0, 7)), 4'($urandom),
             ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom)};
      port = ($urandom_range(0, 7) == 0) ? 16'd5000 : 16'd6000;
      mk(hdr, $urandom_range(0, 6), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1);
      if ($urandom_range(0, 15) == 0) be[0] = 4'($urandom_range(1, 15));
      run_pkt(port, 1);
      end_pkt("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
